raid_drive_responder: RTL and testbench
=======================================

# raid_drive_responder

Single-drive endpoint for the RAID striping controllers, sitting on one lane of the controller's per-drive bus. It accepts a read or write strobe plus address/data, asserts `busy` for a fixed access latency, and then commits the write to, or returns the read from, an internal word-addressed store. One instance per drive lane forms the behavioural and synthesizable drive array that the RAID0 and later RAID levels are integrated and verified against.

## Interface

Parameters:
- `DWIDTH`, 32, data word width; matches the controller's `DWIDTHDEVICE`
- `ADDRWIDTH`, 32, address width; matches the controller's `ADDRWIDTHDEVICE`
- `DEPTH`, 256, number of stored words; legal addresses are 0..DEPTH-1
- `LATENCY`, 4, busy cycles per access; legal range is 1..255

Ports:
- `clk`  in  1  sole clock; every register updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `w_en`  in  1  write strobe; driven by the controller's `w_out[i]`
- `r_en`  in  1  read strobe; driven by the controller's `r_out[i]`
- `addr`  in  ADDRWIDTH  word address; driven by the controller's `drive_addr_out` lane i
- `din`  in  DWIDTH  write data; driven by the controller's `drive_dout` lane i
- `dout`  out  DWIDTH  read data; feeds the controller's `drive_din` lane i
- `busy`  out  1  access in progress; feeds the controller's `drive_busy[i]`
- `ack`  out  1  one-cycle pulse marking access completion
- `err`  out  1  one-cycle pulse, coincident with `ack`, flagging a bad request

## Operation

- States: IDLE, WRITE, READ.
- IDLE:
  - `w_en` high: latch `addr` and `din`, load the counter with LATENCY, go to WRITE.
  - `r_en` high with `w_en` low: latch `addr`, load the counter, go to READ.
  - Neither strobe high: stay in IDLE.
- `w_en` and `r_en` high together: the write wins and proceeds normally. The request is flagged bad.
- WRITE/READ:
  - `busy` = 1. The counter decrements each cycle.
  - Strobes are ignored. Inputs are not re-sampled; the latched copies are used.
- Completion (counter = 1 at the edge): return to IDLE and pulse `ack` for one cycle.
  - WRITE: `mem[addr_latched] <= din_latched`.
  - READ: `dout <= mem[addr_latched]`.
- Out-of-range address (`addr_latched >= DEPTH`), checked at full ADDRWIDTH:
  - WRITE drops the data and leaves memory untouched.
  - READ loads `dout` with 0.
  - In both cases the request is flagged bad.
- Bad request: `err` pulses together with `ack`. The access still completes with normal timing.
- `dout` holds its value until the next READ completes. Writes never change `dout`.
- Counter width is `$clog2(LATENCY+1)`. The counter never wraps below 1 while in WRITE or READ.

## Timing

- Reset values: state IDLE, `busy` 0, `ack` 0, `err` 0, `dout` 0, counter 0.
  - Memory contents are not reset. Simulation initializes memory to 0.
- A request sampled at the edge ending cycle T produces:
  - `busy` = 1 in cycles T+1 .. T+LATENCY.
  - `ack` = 1 and `busy` = 0 in cycle T+LATENCY+1.
  - For reads, `dout` is valid from cycle T+LATENCY+1.
- Back-to-back: a strobe high in the `ack` cycle is accepted. Maximum throughput is one access per LATENCY+1 cycles.
- `busy` is registered and is never high in the same cycle the strobe is first presented. A requester must not sample `busy` until the cycle after its strobe.
- Read-after-write to the same address, issued back-to-back, returns the new data.
- Reset asserted mid-access aborts the access:
  - A pending write is not committed.
  - No `ack` is issued.
  - `busy` is 0 in the cycle after the reset edge.
- `ack` and `err` are never high for more than one consecutive cycle unless consecutive accesses complete. With LATENCY ≥ 1 they cannot complete on consecutive cycles, so back-to-back pulses are always separated by at least one low cycle.

## Test plan

- Reset, then write 0xDEADBEEF to addr 5 (LATENCY=4), then read addr 5:
  - Write: `busy` high exactly 4 cycles, then `ack` pulses.
  - Read: `dout` = 0xDEADBEEF in the read's `ack` cycle, `err` = 0.
- Back-to-back: write 0x11111111 to addr 3, with a read of addr 3 presented in the write's `ack` cycle:
  - The read is accepted.
  - Read `ack` occurs 5 cycles after write `ack` with `dout` = 0x11111111.
- `w_en` and `r_en` both high with addr 7, din 0xA5A5A5A5:
  - The write commits and `err` pulses with `ack`.
  - A subsequent read of addr 7 returns 0xA5A5A5A5.
- Out-of-range access with DEPTH=256:
  - Write 0x12345678 to addr 256: `err` and `ack` pulse.
  - Read addr 256: `dout` = 0, `err` pulses.
  - Read addr 0: returns the prior value (0), proving no aliasing.
- Strobes toggled during `busy` with different addr/din: ignored; only the first request takes effect, and timing is unchanged.
- Reset asserted in the 2nd busy cycle of a write of 0xCAFEF00D to addr 9:
  - No `ack`; `busy` = 0 the next cycle.
  - A later read of addr 9 returns 0, not 0xCAFEF00D.

Source files
------------

// File: rtl/raid_drive_responder.sv
// Single-lane drive endpoint for the RAID striping controllers.
// Fixed-latency word store: busy for LATENCY cycles, then ack (and err if bad).
module raid_drive_responder #(
  parameter int DWIDTH    = 32,
  parameter int ADDRWIDTH = 32,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_en,
  input  logic                 r_en,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0]    din,
  output logic [DWIDTH-1:0]    dout,
  output logic                 busy,
  output logic                 ack,
  output logic                 err
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [ADDRWIDTH-1:0] ADDR_LIM = ADDRWIDTH'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0]    din_q;
  logic                 both_q;

  logic accept;
  logic done;
  logic in_range;
  logic bad;
  logic mem_we;
  logic rd_done;

  logic [IW-1:0] idx;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Range is judged on the full latched address so high bits never alias.
  assign in_range = (addr_q < ADDR_LIM);
  assign bad      = both_q || !in_range;
  assign idx      = addr_q[IW-1:0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (w_en) begin
          state_nx = WRITE;
          cnt_nx   = CNT_LOAD;
          accept   = 1'b1;
        end else if (r_en) begin
          state_nx = READ;
          cnt_nx   = CNT_LOAD;
          accept   = 1'b1;
        end
      end
      WRITE, READ: begin
        if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done     = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_LAST;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign mem_we  = done && (state == WRITE)
                && in_range && !reset;
  assign rd_done = done && (state == READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      dout   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      both_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state_nx != IDLE);
      ack   <= done;
      err   <= done && bad;
      if (accept) begin
        addr_q <= addr;
        both_q <= w_en && r_en;
        if (w_en) begin
          din_q <= din;
        end
      end
      if (rd_done) begin
        dout <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= din_q;
    end
  end

endmodule

// File: tb/tb_raid_drive_responder.sv
// Scoreboard bench for raid_drive_responder.
// Driver queues expected completions; a negedge monitor checks each ack.
module tb_raid_drive_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        busy;
  logic        ack;
  logic        err;

  raid_drive_responder #(
    .DWIDTH(32),
    .ADDRWIDTH(32),
    .DEPTH(256),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_en(w_en),
    .r_en(r_en),
    .addr(addr),
    .din(din),
    .dout(dout),
    .busy(busy),
    .ack(ack),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ack_cyc;
    logic        chk;
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_run = 0;
  logic [31:0] last_dout = '0;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!done && !reset) begin
      if (ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("busy_in_ack", 32'(busy), 32'h0);
          check("busy_len", 32'(busy_run), 32'(LAT));
          check("err", 32'(err), 32'(e.err));
          if (e.chk) check("dout", dout, e.dout);
        end
      end else begin
        if (err) check("err_without_ack", 32'(err), 32'h0);
        if (sb.size() > 0 && cyc > sb[0].ack_cyc) begin
          check("ack_missing", 32'(ack), 32'h1);
          void'(sb.pop_front());
        end
      end
    end
    if (reset || !busy) busy_run = 0;
    else busy_run++;
  end

  task automatic push_exp(input logic is_rd,
                          input logic [31:0] rd_val,
                          input logic e_err);
    exp_t e;
    e.ack_cyc = cyc + LAT + 1;
    e.chk = 1'b1;
    if (is_rd) last_dout = rd_val;
    e.dout = last_dout;
    e.err = e_err;
    sb.push_back(e);
  endtask

  // Presents a request for one cycle, optionally drives junk while busy,
  // and returns positioned in the ack cycle so the next call is back-to-back.
  task automatic access(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd_val, input logic e_err,
                        input logic noisy);
    push_exp(r && !w, rd_val, e_err);
    w_en = w; r_en = r; addr = a; din = d;
    @(posedge clk); #1;
    w_en = 0; r_en = 0;
    for (int i = 0; i < LAT; i++) begin
      if (noisy) begin
        w_en = i[0]; r_en = ~i[0];
        addr = a ^ 32'h3; din = ~d;
      end
      @(posedge clk); #1;
    end
    w_en = 0; r_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle(3);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dout", dout, 32'h0);
    reset = 0;
    idle(2);

    access(1, 0, 32'd0, 32'h0, '0, 0, 0);
    access(1, 0, 32'd9, 32'h0, '0, 0, 0);
    idle(1);

    access(1, 0, 32'd5, 32'hDEADBEEF, '0, 0, 0);
    idle(2);
    access(0, 1, 32'd5, '0, 32'hDEADBEEF, 0, 0);

    access(1, 0, 32'd3, 32'h11111111, '0, 0, 0);
    access(0, 1, 32'd3, '0, 32'h11111111, 0, 0);

    access(1, 1, 32'd7, 32'hA5A5A5A5, '0, 1, 0);
    access(0, 1, 32'd7, '0, 32'hA5A5A5A5, 0, 0);

    access(1, 0, 32'd256, 32'h12345678, '0, 1, 0);
    access(0, 1, 32'd256, '0, 32'h0, 1, 0);
    access(0, 1, 32'd0, '0, 32'h0, 0, 0);
    access(0, 1, 32'd7, '0, 32'hA5A5A5A5, 0, 0);
    access(0, 1, 32'h80000005, '0, 32'h0, 1, 0);

    access(1, 0, 32'd20, 32'h55AA55AA, '0, 0, 1);
    access(0, 1, 32'd20, '0, 32'h55AA55AA, 0, 0);
    access(0, 1, 32'd5, '0, 32'hDEADBEEF, 0, 1);
    idle(1);
    access(0, 1, 32'd23, '0, 32'h0, 0, 0);

    w_en = 1; addr = 32'd9; din = 32'hCAFEF00D;
    @(posedge clk); #1;
    w_en = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("busy_after_abort", 32'(busy), 32'h0);
    check("dout_after_abort", dout, 32'h0);
    last_dout = '0;
    idle(LAT + 3);
    check("busy_stays_low", 32'(busy), 32'h0);
    access(0, 1, 32'd9, '0, 32'h0, 0, 0);

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'h0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
